// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
// Frame layout: LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, optional CSUM byte.
package prog_loader_pkg;

  // Stream byte, length field and instruction word widths.
  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // The IDLE state waits for LEN_HI; each other state is named after the byte it waits for.
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    START,
    ERR,
    DONE
  } state_t;

  // True while a frame is open and the inter-byte timer is running.
  function automatic logic in_frame(input state_t s);
    return s inside {LEN_LO, DATA_HI, DATA_LO, CSUM};
  endfunction

  // True in the resting states where the next accepted byte opens a new frame.
  function automatic logic is_rest(input state_t s);
    return s inside {IDLE, DONE, ERR};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in, instruction-memory write port and CPU control out.
// master = loader side, slave = environment (byte source, imem, CPU).
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;

  logic              imem_we;
  logic [LEN_W-1:0]  imem_waddr;
  logic [WORD_W-1:0] imem_wdata;

  logic              cpu_start;
  logic              cpu_stop;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready,
    output imem_we, imem_waddr, imem_wdata,
    output cpu_start, cpu_stop, busy, done, err
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready,
    input  imem_we, imem_waddr, imem_wdata,
    input  cpu_start, cpu_stop, busy, done, err
  );

endinterface

// File: rtl/prog_loader_timeout.sv
// loader_timeout: inter-byte idle watchdog for the program loader.
// Reloaded on every accepted byte, counts down once per idle in-frame cycle and
// flags expiry on the TIMEOUT_CYCLES-th consecutive idle cycle. TIMEOUT_CYCLES=0 disables it.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,  // byte accepted: reload the full budget
  input  logic tick,     // idle cycle inside a frame
  output logic expired   // this idle cycle exhausts the budget
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      logic [CNT_W-1:0] cnt;

      // Remaining idle cycles before the frame is abandoned.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (restart) begin
          cnt <= LOAD_VAL;
        end else if (tick && (cnt != '0)) begin
          cnt <= cnt - ONE;
        end
      end

      // Expiry only on an idle cycle, so a byte arriving on the last cycle still wins.
      assign expired = tick && (cnt == ONE);
    end
  endgenerate

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a program frame from a byte stream into instruction memory,
// holds the CPU stopped while loading and pulses cpu_start on a good frame.
// Build macro LOADER_CHECKSUM_EN: frames end with a CSUM byte (XOR of all prior frame
// bytes); mismatch rejects the frame. Undefined: START follows the last data word directly.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned IMEMSIZE       = 256,    // words; must fit in LEN_W bits
  parameter int unsigned TIMEOUT_CYCLES = 65535   // 0 disables the inter-byte timeout
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IMEMSIZE);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = START;
`endif

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              timeout_hit;
  logic              last_word;
  logic [LEN_W-1:0]  len;       // word count N; high byte lands first
  logic [LEN_W-1:0]  len_rx;    // full length as it completes on the LEN_LO byte
  logic [LEN_W-1:0]  idx;       // next word address to write
  logic [BYTE_W-1:0] data_hi;   // staged high byte of the current word
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;      // running XOR of length and data bytes
`endif

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign len_rx    = {len[LEN_W-1:BYTE_W], bus.rx_data};
  assign last_word = (idx + ONE) == len;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (in_frame(state) && !accept),
    .expired(timeout_hit)
  );

  // State register.
  // NOTE: reset is asynchronous: the loader drops back to IDLE the instant rst rises,
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      state <= next_state;
    end
  end

  // Next-state decode from the current state and the byte being accepted.
  always_comb begin
    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (accept) next_state = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (len_rx > MAX_LEN)    next_state = ERR;
          else if (len_rx == '0)   next_state = AFTER_DATA;
          else                     next_state = DATA_HI;
        end
      end
      DATA_HI: begin
        if (accept) next_state = DATA_LO;
      end
      DATA_LO: begin
        if (accept) next_state = last_word ? AFTER_DATA : DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) next_state = (bus.rx_data == csum) ? START : ERR;
      end
`endif
      START: begin
        next_state = DONE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // Expiry only fires on an idle in-frame cycle, so it never competes with a byte.
    if (timeout_hit) next_state = ERR;
  end

  // Frame datapath: capture length, stage the high byte, advance the word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len     <= '0;
      idx     <= '0;
      data_hi <= '0;
    end else if (accept) begin
      case (state)
        IDLE, DONE, ERR: begin
          len <= {bus.rx_data, BYTE_W'(0)};
          idx <= '0;
        end
        LEN_LO:  len[BYTE_W-1:0] <= bus.rx_data;
        DATA_HI: data_hi <= bus.rx_data;
        DATA_LO: idx <= idx + ONE;
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over the length and data bytes; restarts on the first byte of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (accept) begin
      csum <= is_rest(state) ? bus.rx_data : (csum ^ bus.rx_data);
    end
  end
`endif

  // Registered outputs, decoded from the state being entered so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_ready   <= 1'b1;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_start  <= 1'b0;
      bus.cpu_stop   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.rx_ready  <= (next_state != START);
      bus.cpu_start <= (next_state == START);
      bus.cpu_stop  <= in_frame(next_state);
      bus.busy      <= !is_rest(next_state);
      bus.done      <= (next_state == START) || (next_state == DONE);
      bus.err       <= (next_state == ERR);
      bus.imem_we   <= accept && (state == DATA_LO);
      if (accept && (state == DATA_LO)) begin
        bus.imem_waddr <= idx;
        bus.imem_wdata <= {data_hi, bus.rx_data};
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized scoreboard bench for prog_loader.
// The frame model builds each frame's bytes and the words/start it must produce;
// a negedge monitor pops expected writes and start pulses as the DUT presents them.
module tb_prog_loader;

  localparam int IMEMSIZE = 256;
  localparam int TIMEOUT  = 8;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic rst;

  prog_loader_if bus ();

  prog_loader #(
    .IMEMSIZE      (IMEMSIZE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  wr_t         wq[$];            // expected imem writes, in order
  int          starts_expected = 0;
  logic [15:0] dir_words[$];     // directed data words; random when empty
  logic        prev_start = 1'b0;
  wr_t         got_w;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_bit({tag, "_rx_ready"},  bus.rx_ready,  1'b1);
    check_bit({tag, "_imem_we"},   bus.imem_we,   1'b0);
    check_val({tag, "_imem_waddr"}, 32'(bus.imem_waddr), 32'h0);
    check_val({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'h0);
    check_bit({tag, "_cpu_start"}, bus.cpu_start, 1'b0);
    check_bit({tag, "_cpu_stop"},  bus.cpu_stop,  1'b0);
    check_bit({tag, "_busy"},      bus.busy,      1'b0);
    check_bit({tag, "_done"},      bus.done,      1'b0);
    check_bit({tag, "_err"},       bus.err,       1'b0);
  endtask

  // Offer one byte after `gap` idle cycles; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    guard = 0;
    while (bus.rx_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_bit("rx_ready_wait", bus.rx_ready, 1'b1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Build a frame of n words, predict its effect, send it and check the outcome.
  // cmask corrupts the checksum byte; gap < 0 picks a random 0..4 idle gap per byte.
  task automatic run_frame(input int n, input logic [7:0] cmask, input int gap);
    logic [7:0]  q[$];
    logic [15:0] n16;
    logic [15:0] w;
    wr_t         e;
    bit          good;
    n16 = 16'(n);
    q.push_back(n16[15:8]);
    q.push_back(n16[7:0]);
    good = (n <= IMEMSIZE);
    if (good) begin
      for (int i = 0; i < n; i++) begin
        w = (dir_words.size() > 0) ? dir_words.pop_front() : 16'($urandom);
        q.push_back(w[15:8]);
        q.push_back(w[7:0]);
        e.addr = 16'(i);
        e.data = w;
        wq.push_back(e);
      end
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] cs;
        cs = 8'h00;
        foreach (q[k]) cs = cs ^ q[k];
        q.push_back(cs ^ cmask);
        good = (cmask == 8'h00);
      end
`else
      good = good && (cmask == 8'h00);
`endif
    end
    if (good) starts_expected++;

    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i], (gap < 0) ? int'($urandom_range(4, 0)) : gap);
      if (i == 0) begin
        check_bit("open_cpu_stop", bus.cpu_stop, 1'b1);
        check_bit("open_busy",     bus.busy,     1'b1);
        check_bit("open_done",     bus.done,     1'b0);
        check_bit("open_err",      bus.err,      1'b0);
      end
    end
    // One cycle after the last byte: start pulse or rejection.
    check_bit("last_cpu_start", bus.cpu_start, good);
    check_bit("last_err",       bus.err,       !good);
    check_bit("last_rx_ready",  bus.rx_ready,  !good);
    @(negedge clk);
    #1;
    check_bit("end_done",      bus.done,      good);
    check_bit("end_err",       bus.err,       !good);
    check_bit("end_cpu_start", bus.cpu_start, 1'b0);
    check_bit("end_cpu_stop",  bus.cpu_stop,  1'b0);
    check_bit("end_busy",      bus.busy,      1'b0);
    check_val("writes_left",   32'(wq.size()),        32'd0);
    check_val("starts_left",   32'(starts_expected),  32'd0);
  endtask

  // Monitor: every write and start pulse the DUT presents is matched against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.imem_we === 1'b1) begin
        if (wq.size() == 0) begin
          check_bit("unexpected_imem_we", bus.imem_we, 1'b0);
        end else begin
          got_w = wq.pop_front();
          check_val("imem_waddr", 32'(bus.imem_waddr), 32'(got_w.addr));
          check_val("imem_wdata", 32'(bus.imem_wdata), 32'(got_w.data));
        end
      end
      if (bus.cpu_start === 1'b1) begin
        check_bit("cpu_start_expected", starts_expected > 0, 1'b1);
        if (starts_expected > 0) starts_expected--;
        check_bit("cpu_start_width",  prev_start,   1'b0);
        check_bit("rx_ready_in_start", bus.rx_ready, 1'b0);
      end
      prev_start = bus.cpu_start;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    logic [7:0] m;
    wr_t        e;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset");

    // Two-word frame 00 02 12 34 AB CD [csum].
    dir_words = {16'h1234, 16'hABCD};
    run_frame(2, 8'h00, 0);

`ifdef LOADER_CHECKSUM_EN
    // Same frame with checksum off by one bit: words written, no start.
    dir_words = {16'h1234, 16'hABCD};
    run_frame(2, 8'h01, 0);
`endif

    // N = 257 exceeds the memory: rejected on LEN_LO, nothing written.
    run_frame(257, 8'h00, 0);
    // Empty frame: no writes, start one cycle after the last byte.
    run_frame(0, 8'h00, 0);
    // Largest legal frame fills every word.
    run_frame(IMEMSIZE, 8'h00, 0);
    // Every byte lands on the last idle cycle the timer allows.
    run_frame(3, 8'h00, TIMEOUT - 1);

    // Stall after 00 02 12: error on the TIMEOUT-th idle cycle, not before.
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_bit("timeout_early_err",  bus.err,      1'b0);
    check_bit("timeout_early_stop", bus.cpu_stop, 1'b1);
    @(negedge clk);
    check_bit("timeout_err",        bus.err,       1'b1);
    check_bit("timeout_stop",       bus.cpu_stop,  1'b0);
    check_bit("timeout_busy",       bus.busy,      1'b0);
    check_bit("timeout_no_start",   bus.cpu_start, 1'b0);

    // Reset after the third data byte: first word already written, rest discarded.
    e.addr = 16'h0000;
    e.data = 16'h1234;
    wq.push_back(e);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    rst = 1'b1;
    #1;
    check_reset_values("mid_frame_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_writes_left", 32'(wq.size()), 32'd0);
    check_bit("reset_no_start",    bus.cpu_start,  1'b0);
    dir_words = {16'hBEEF};
    run_frame(1, 8'h00, 0);

    // Random frames: mostly short and legal, some oversized, some corrupted.
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(7, 0) == 0) n = int'($urandom_range(65535, IMEMSIZE + 1));
      else                           n = int'($urandom_range(8, 0));
`ifdef LOADER_CHECKSUM_EN
      m = ($urandom_range(3, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
`else
      m = 8'h00;
`endif
      run_frame(n, m, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
